// File: rtl/udma_smi_autopoll.sv
// -----------------------------------------------------------------------------
// udma_smi_autopoll
//
// Purpose:
//   Sits between the SMI software register interface and the MDIO serial
//   engine. It forwards software read/write transactions. When polling is
//   enabled, it also issues periodic reads of one PHY register. A change in the
//   masked bits of the polled value is reported as a one-cycle event.
//   Software requests always take priority over polls, and the engine only
//   ever sees one transaction at a time.
//
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   sw_start_i            one-cycle software request strobe (ignored while busy)
//   sw_rw_i               1 = read, 0 = write
//   sw_phy_addr_i         software PHY address
//   sw_reg_addr_i         software register address
//   sw_wr_data_i          software write data
//   sw_busy_o             software request pending or in flight
//   sw_nd_o               one-cycle software-done pulse
//   sw_rd_data_o          software read data, valid from sw_nd_o onward
//   poll_en_i             enable periodic polling
//   poll_phy_addr_i       polled PHY address
//   poll_reg_addr_i       polled register address
//   poll_mask_i           bits compared for the change event
//   poll_interval_i       cycles between poll issues
//   poll_status_o         last polled register value
//   poll_valid_o          poll_status_o holds a value read while enabled
//   poll_evt_o            one-cycle pulse: masked bits changed
//   start_o               one-cycle start strobe to the MDIO engine
//   rw_o, phy_addr_o,
//   reg_addr_o, wr_data_o transaction fields to the engine, stable per transaction
//   busy_i                engine busy
//   nd_i                  engine read-data-valid pulse
//   rd_data_i             engine read data
// -----------------------------------------------------------------------------
module udma_smi_autopoll #(
  parameter int INTERVAL_W = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  sw_start_i,
  input  logic                  sw_rw_i,
  input  logic [4:0]            sw_phy_addr_i,
  input  logic [4:0]            sw_reg_addr_i,
  input  logic [15:0]           sw_wr_data_i,
  output logic                  sw_busy_o,
  output logic                  sw_nd_o,
  output logic [15:0]           sw_rd_data_o,

  input  logic                  poll_en_i,
  input  logic [4:0]            poll_phy_addr_i,
  input  logic [4:0]            poll_reg_addr_i,
  input  logic [15:0]           poll_mask_i,
  input  logic [INTERVAL_W-1:0] poll_interval_i,
  output logic [15:0]           poll_status_o,
  output logic                  poll_valid_o,
  output logic                  poll_evt_o,

  output logic                  start_o,
  output logic                  rw_o,
  output logic [4:0]            phy_addr_o,
  output logic [4:0]            reg_addr_o,
  output logic [15:0]           wr_data_o,
  input  logic                  busy_i,
  input  logic                  nd_i,
  input  logic [15:0]           rd_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  typedef enum logic {
    OWN_SW,
    OWN_POLL
  } owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q;

  // Latched software request
  logic                  sw_pend_q;
  logic                  sw_rw_q;
  logic [4:0]            sw_phy_q;
  logic [4:0]            sw_reg_q;
  logic [15:0]           sw_wd_q;

  logic [INTERVAL_W-1:0] cnt_q;
  logic [15:0]           poll_rd_q;
  logic                  poll_drop_q;

  logic                  sw_accept;
  logic                  sw_req;
  logic                  poll_pend;
  logic                  sel_sw;
  logic                  sel_poll;
  logic                  xfer_done;
  logic                  poll_update;
  logic [15:0]           poll_new;

  // A strobe accepted while IDLE is issued straight away instead of waiting a
  // cycle in the latch. This lets a request that arrives in the same cycle the
  // poll counter expires still win arbitration.
  assign sw_accept   = sw_start_i & ~sw_busy_o;
  assign sw_req      = sw_pend_q | sw_accept;
  assign poll_pend   = poll_en_i & (cnt_q == '0);
  assign xfer_done   = (state_q == WAIT_DONE) & ~busy_i;
  assign start_o     = (state_q == ISSUE);

  // nd_i may coincide with the final busy cycle, so take the live data then.
  assign poll_new    = nd_i ? rd_data_i : poll_rd_q;
  assign poll_update = xfer_done & (owner_q == OWN_POLL) & poll_en_i & ~poll_drop_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path
    // can leave one unassigned and no latch is inferred.
    state_d  = state_q;
    sel_sw   = 1'b0;
    sel_poll = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sw_req) begin
          sel_sw  = 1'b1;
          state_d = ISSUE;
        end else if (poll_pend) begin
          sel_poll = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (busy_i)  state_d = WAIT_DONE;
      WAIT_DONE: if (!busy_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, ownership and engine-facing transaction fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= OWN_SW;
      rw_o       <= 1'b0;
      phy_addr_o <= '0;
      reg_addr_o <= '0;
      wr_data_o  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register here samples the values from before the clock edge.
      state_q <= state_d;
      if (sel_sw) begin
        owner_q    <= OWN_SW;
        rw_o       <= sw_pend_q ? sw_rw_q  : sw_rw_i;
        phy_addr_o <= sw_pend_q ? sw_phy_q : sw_phy_addr_i;
        reg_addr_o <= sw_pend_q ? sw_reg_q : sw_reg_addr_i;
        wr_data_o  <= sw_pend_q ? sw_wd_q  : sw_wr_data_i;
      end else if (sel_poll) begin
        owner_q    <= OWN_POLL;
        rw_o       <= 1'b1;
        phy_addr_o <= poll_phy_addr_i;
        reg_addr_o <= poll_reg_addr_i;
        wr_data_o  <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Software request latch and completion
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the data registers are reset as well as the control registers,
      // because every output has to read 0 after reset.
      sw_pend_q    <= 1'b0;
      sw_rw_q      <= 1'b0;
      sw_phy_q     <= '0;
      sw_reg_q     <= '0;
      sw_wd_q      <= '0;
      sw_busy_o    <= 1'b0;
      sw_nd_o      <= 1'b0;
      sw_rd_data_o <= '0;
    end else begin
      if (sw_accept) begin
        sw_rw_q  <= sw_rw_i;
        sw_phy_q <= sw_phy_addr_i;
        sw_reg_q <= sw_reg_addr_i;
        sw_wd_q  <= sw_wr_data_i;
      end

      if (sel_sw)         sw_pend_q <= 1'b0;
      else if (sw_accept) sw_pend_q <= 1'b1;

      // Busy stays high through the sw_nd_o cycle and drops the cycle after.
      if (sw_nd_o)        sw_busy_o <= 1'b0;
      else if (sw_accept) sw_busy_o <= 1'b1;

      sw_nd_o <= xfer_done & (owner_q == OWN_SW);

      // Writes leave the read register untouched.
      if ((state_q == WAIT_DONE) && nd_i && (owner_q == OWN_SW) && rw_o)
        sw_rd_data_o <= rd_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Poll interval counter, status and change event
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      poll_rd_q     <= '0;
      poll_drop_q   <= 1'b0;
      poll_status_o <= '0;
      poll_valid_o  <= 1'b0;
      poll_evt_o    <= 1'b0;
    end else begin
      if ((state_q == ISSUE) && (owner_q == OWN_POLL))
        cnt_q <= poll_interval_i;
      else if (poll_en_i && (cnt_q != '0))
        cnt_q <= cnt_q - 1'b1;

      if ((state_q == WAIT_DONE) && nd_i && (owner_q == OWN_POLL))
        poll_rd_q <= rd_data_i;

      // Once polling is disabled during an in-flight poll, its result is
      // discarded even if polling is re-enabled before it completes.
      if (state_q == IDLE)
        poll_drop_q <= 1'b0;
      else if ((owner_q == OWN_POLL) && !poll_en_i)
        poll_drop_q <= 1'b1;

      poll_evt_o <= poll_update & poll_valid_o &
                    (((poll_new ^ poll_status_o) & poll_mask_i) != '0);

      if (poll_update)
        poll_status_o <= poll_new;

      if (!poll_en_i)       poll_valid_o <= 1'b0;
      else if (poll_update) poll_valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udma_smi_autopoll.sv
// -----------------------------------------------------------------------------
// tb_udma_smi_autopoll
//
// Directed self-checking bench for udma_smi_autopoll. The bench stands in for
// the MDIO engine inline: once start_o is seen, it raises busy_i, optionally
// pulses nd_i with read data, and then drops busy_i.
//
// Timing: inputs are driven and outputs sampled 1 time unit after each posedge.
// When the engine is served from a start cycle S:
//   S+1 WAIT_BUSY, S+2 WAIT_DONE (nd_i driven), S+3 busy_i low, and
//   S+4 back in IDLE with sw_nd_o / poll update visible.
// The poll counter loads the interval at the end of the poll's start cycle, so
// it reads 0 at S+1+interval. IDLE selects the poll in that cycle, and the next
// poll start is at S+2+interval.
// -----------------------------------------------------------------------------
module tb_udma_smi_autopoll;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sw_start_i, sw_rw_i;
  logic [4:0]  sw_phy_addr_i, sw_reg_addr_i;
  logic [15:0] sw_wr_data_i;
  logic        sw_busy_o, sw_nd_o;
  logic [15:0] sw_rd_data_o;
  logic        poll_en_i;
  logic [4:0]  poll_phy_addr_i, poll_reg_addr_i;
  logic [15:0] poll_mask_i;
  logic [23:0] poll_interval_i;
  logic [15:0] poll_status_o;
  logic        poll_valid_o, poll_evt_o;
  logic        start_o, rw_o;
  logic [4:0]  phy_addr_o, reg_addr_o;
  logic [15:0] wr_data_o;
  logic        busy_i, nd_i;
  logic [15:0] rd_data_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  udma_smi_autopoll #(.INTERVAL_W(24)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .sw_start_i      (sw_start_i),
    .sw_rw_i         (sw_rw_i),
    .sw_phy_addr_i   (sw_phy_addr_i),
    .sw_reg_addr_i   (sw_reg_addr_i),
    .sw_wr_data_i    (sw_wr_data_i),
    .sw_busy_o       (sw_busy_o),
    .sw_nd_o         (sw_nd_o),
    .sw_rd_data_o    (sw_rd_data_o),
    .poll_en_i       (poll_en_i),
    .poll_phy_addr_i (poll_phy_addr_i),
    .poll_reg_addr_i (poll_reg_addr_i),
    .poll_mask_i     (poll_mask_i),
    .poll_interval_i (poll_interval_i),
    .poll_status_o   (poll_status_o),
    .poll_valid_o    (poll_valid_o),
    .poll_evt_o      (poll_evt_o),
    .start_o         (start_o),
    .rw_o            (rw_o),
    .phy_addr_o      (phy_addr_o),
    .reg_addr_o      (reg_addr_o),
    .wr_data_o       (wr_data_o),
    .busy_i          (busy_i),
    .nd_i            (nd_i),
    .rd_data_i       (rd_data_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All outputs packed together for the "everything is zero" checks.
  function automatic logic [63:0] all_outs();
    return {sw_busy_o, sw_nd_o, sw_rd_data_o, poll_status_o, poll_valid_o,
            poll_evt_o, start_o, rw_o, phy_addr_o, reg_addr_o, wr_data_o};
  endfunction

  // Advance until start_o is seen; returns the cycle number of the start.
  task automatic wait_start(input string tag, output int sc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (start_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_start_seen"}, 64'(ok), 64'd1);
    sc = cyc;
  endtask

  // Engine stand-in, entered in the start cycle S and leaving in cycle S+4.
  // With pulse_sw set, a second software strobe is driven for one cycle while
  // the transaction is in flight; it must be ignored.
  task automatic serve(input string tag, input logic [15:0] data, input bit do_nd,
                       input bit pulse_sw);
    busy_i = 1'b1;
    if (pulse_sw) begin
      sw_start_i    = 1'b1;
      sw_rw_i       = 1'b0;
      sw_phy_addr_i = 5'd7;
      sw_reg_addr_i = 5'd9;
      sw_wr_data_i  = 16'hDEAD;
    end
    tick();
    sw_start_i = 1'b0;
    check({tag, "_start_one_cycle"}, 64'(start_o), 64'd0);
    tick();
    if (do_nd) begin
      nd_i      = 1'b1;
      rd_data_i = data;
    end
    tick();
    nd_i      = 1'b0;
    rd_data_i = 16'h0000;
    busy_i    = 1'b0;
    tick();
  endtask

  initial begin
    int t0, s1, s2, s3, s4, s5, s6;

    rst_i           = 1'b1;
    sw_start_i      = 1'b0;
    sw_rw_i         = 1'b0;
    sw_phy_addr_i   = '0;
    sw_reg_addr_i   = '0;
    sw_wr_data_i    = '0;
    poll_en_i       = 1'b0;
    poll_phy_addr_i = '0;
    poll_reg_addr_i = '0;
    poll_mask_i     = '0;
    poll_interval_i = '0;
    busy_i          = 1'b0;
    nd_i            = 1'b0;
    rd_data_i       = '0;

    // ---- Reset state ------------------------------------------------------
    tick();
    tick();
    check("reset_outputs", all_outs(), 64'd0);
    rst_i = 1'b0;
    tick();
    check("idle_outputs", all_outs(), 64'd0);

    // ---- SW read phy=5 reg=1 -> 0x796D -------------------------------------
    sw_start_i    = 1'b1;
    sw_rw_i       = 1'b1;
    sw_phy_addr_i = 5'd5;
    sw_reg_addr_i = 5'd1;
    sw_wr_data_i  = 16'hAAAA;
    t0 = cyc;
    tick();
    sw_start_i = 1'b0;
    wait_start("swrd", s1);
    check("swrd_latency", 64'(s1 - t0), 64'd1);
    check("swrd_busy", 64'(sw_busy_o), 64'd1);
    check("swrd_fields", {rw_o, phy_addr_o, reg_addr_o}, {1'b1, 5'd5, 5'd1});
    serve("swrd", 16'h796D, 1'b1, 1'b0);
    check("swrd_nd", 64'(sw_nd_o), 64'd1);
    check("swrd_data", 64'(sw_rd_data_o), 64'h796D);
    check("swrd_busy_at_nd", 64'(sw_busy_o), 64'd1);
    tick();
    check("swrd_nd_low", 64'(sw_nd_o), 64'd0);
    check("swrd_busy_low", 64'(sw_busy_o), 64'd0);
    check("swrd_no_reissue", 64'(start_o), 64'd0);

    // ---- SW write reg=0 data=0x8000 ----------------------------------------
    sw_start_i    = 1'b1;
    sw_rw_i       = 1'b0;
    sw_phy_addr_i = 5'd5;
    sw_reg_addr_i = 5'd0;
    sw_wr_data_i  = 16'h8000;
    tick();
    sw_start_i = 1'b0;
    wait_start("swwr", s1);
    check("swwr_fields", {rw_o, reg_addr_o, wr_data_o}, {1'b0, 5'd0, 16'h8000});
    serve("swwr", 16'h0000, 1'b0, 1'b0);
    check("swwr_nd", 64'(sw_nd_o), 64'd1);
    check("swwr_rd_unchanged", 64'(sw_rd_data_o), 64'h796D);
    tick();
    check("swwr_nd_low", 64'(sw_nd_o), 64'd0);

    // ---- Polling, interval=100, mask=0x0004 --------------------------------
    poll_phy_addr_i = 5'd5;
    poll_reg_addr_i = 5'd1;
    poll_mask_i     = 16'h0004;
    poll_interval_i = 24'd100;
    poll_en_i       = 1'b1;
    tick();
    wait_start("poll1", s1);
    check("poll1_fields", {rw_o, phy_addr_o, reg_addr_o, wr_data_o},
          {1'b1, 5'd5, 5'd1, 16'h0000});
    check("poll1_valid_before", 64'(poll_valid_o), 64'd0);
    serve("poll1", 16'h7849, 1'b1, 1'b0);
    check("poll1_valid", 64'(poll_valid_o), 64'd1);
    check("poll1_no_evt", 64'(poll_evt_o), 64'd0);
    check("poll1_status", 64'(poll_status_o), 64'h7849);
    check("poll1_sw_idle", 64'({sw_busy_o, sw_nd_o}), 64'd0);

    wait_start("poll2", s2);
    check("poll2_spacing", 64'(s2 - s1), 64'd102);
    serve("poll2", 16'h784D, 1'b1, 1'b0);
    check("poll2_evt", 64'(poll_evt_o), 64'd1);
    check("poll2_status", 64'(poll_status_o), 64'h784D);
    tick();
    check("poll2_evt_one_cycle", 64'(poll_evt_o), 64'd0);

    // ---- mask=0: status tracks, no event -----------------------------------
    poll_mask_i = 16'h0000;
    wait_start("poll3", s3);
    serve("poll3", 16'h7849, 1'b1, 1'b0);
    check("poll3_no_evt", 64'(poll_evt_o), 64'd0);
    check("poll3_status", 64'(poll_status_o), 64'h7849);
    wait_start("poll4", s4);
    serve("poll4", 16'h784D, 1'b1, 1'b0);
    check("poll4_no_evt", 64'(poll_evt_o), 64'd0);
    check("poll4_status", 64'(poll_status_o), 64'h784D);

    // ---- SW strobe in the cycle the counter reaches 0 ----------------------
    for (int i = 0; i < 200 && cyc < s4 + 101; i++) tick();
    check("arb_idle_before", 64'(start_o), 64'd0);
    sw_start_i    = 1'b1;
    sw_rw_i       = 1'b1;
    sw_phy_addr_i = 5'd3;
    sw_reg_addr_i = 5'd2;
    tick();
    sw_start_i = 1'b0;
    check("arb_sw_first", {start_o, phy_addr_o, reg_addr_o}, {1'b1, 5'd3, 5'd2});
    serve("arb_sw", 16'h1234, 1'b1, 1'b1);
    check("arb_sw_nd", 64'(sw_nd_o), 64'd1);
    check("arb_sw_data", 64'(sw_rd_data_o), 64'h1234);
    tick();
    s5 = cyc;
    check("arb_poll_next", {start_o, rw_o, phy_addr_o, reg_addr_o},
          {1'b1, 1'b1, 5'd5, 5'd1});
    check("arb_second_strobe_ignored", 64'(sw_busy_o), 64'd0);
    serve("arb_poll", 16'h784D, 1'b1, 1'b0);
    check("arb_poll_status", 64'(poll_status_o), 64'h784D);
    check("arb_sw_quiet", {sw_busy_o, sw_nd_o, sw_rd_data_o}, {1'b0, 1'b0, 16'h1234});

    // ---- Drop poll_en during a poll, then reset mid SW transaction --------
    wait_start("poll6", s6);
    check("poll6_spacing", 64'(s6 - s5), 64'd102);
    poll_en_i = 1'b0;
    serve("poll6", 16'h0000, 1'b1, 1'b0);
    check("drop_valid", 64'(poll_valid_o), 64'd0);
    check("drop_discarded", 64'(poll_status_o), 64'h784D);
    check("drop_no_evt", 64'(poll_evt_o), 64'd0);

    sw_start_i    = 1'b1;
    sw_rw_i       = 1'b1;
    sw_phy_addr_i = 5'd5;
    sw_reg_addr_i = 5'd1;
    tick();
    sw_start_i = 1'b0;
    check("rst_sw_start", 64'(start_o), 64'd1);
    busy_i = 1'b1;
    tick();
    tick();
    rst_i  = 1'b1;
    busy_i = 1'b0;
    tick();
    check("midrst_outputs", all_outs(), 64'd0);
    rst_i = 1'b0;
    tick();
    check("postrst_outputs", all_outs(), 64'd0);

    // A fresh request must issue with single-cycle latency, which it can only
    // do from IDLE.
    sw_start_i    = 1'b1;
    sw_rw_i       = 1'b0;
    sw_phy_addr_i = 5'd2;
    sw_reg_addr_i = 5'd4;
    sw_wr_data_i  = 16'h0F0F;
    tick();
    sw_start_i = 1'b0;
    check("postrst_idle_issue", {start_o, rw_o, wr_data_o}, {1'b1, 1'b0, 16'h0F0F});
    serve("postrst", 16'h0000, 1'b0, 1'b0);
    check("postrst_nd", 64'(sw_nd_o), 64'd1);
    check("postrst_rd_zero", 64'(sw_rd_data_o), 64'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
